// File: rtl/muldiv_pkg.sv
// Shared constants for the RV32M multiply/divide unit: operand width,
// iteration counter width, M-extension funct3 codes, FSM state encoding
// and a conditional two's-complement helper used for sign fix-up.
package muldiv_pkg;

  localparam int XLEN      = 32;
  localparam int ITER_BITS = 6;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  // Two's-complement negate of a word when neg is set, pass-through otherwise.
  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
    if (neg) begin
      cond_neg = (~v) + XLEN'(1);
    end else begin
      cond_neg = v;
    end
  endfunction

  // Same as cond_neg for the double-width product.
  function automatic logic [2*XLEN-1:0] cond_neg2(input logic [2*XLEN-1:0] v, input logic neg);
    if (neg) begin
      cond_neg2 = (~v) + (2*XLEN)'(1);
    end else begin
      cond_neg2 = v;
    end
  endfunction

endpackage

// File: rtl/muldiv_divstep.sv
// One combinational restoring-division step. The {remainder, quotient}
// pair shifts left by one; the shifted-in dividend bit joins the partial
// remainder, the divisor is subtracted when it fits, and the resulting
// quotient bit enters at the bottom.
module muldiv_divstep
  import muldiv_pkg::*;
(
  input  logic [2*XLEN-1:0] i_acc,
  input  logic [XLEN-1:0]   i_divisor,
  output logic [2*XLEN-1:0] o_acc
);

  logic [XLEN:0]   w_trial;
  logic [XLEN-1:0] w_diff;
  logic            w_fits;

  // Trial subtraction and restore decision for one quotient bit.
  always_comb begin
    w_trial = {i_acc[2*XLEN-1:XLEN], i_acc[XLEN-1]};
    w_fits  = (w_trial >= {1'b0, i_divisor});
    w_diff  = w_trial[XLEN-1:0] - i_divisor;
    if (w_fits) begin
      o_acc = {w_diff, i_acc[XLEN-2:0], 1'b1};
    end else begin
      o_acc = {w_trial[XLEN-1:0], i_acc[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M multiply/divide unit with a start/busy/done handshake.
// Multiplies are shift-add (one multiplier bit per cycle) and divides are
// restoring (one quotient bit per cycle), both on unsigned magnitudes with
// a final sign fix-up. Divide-by-zero and signed overflow finish at once.
// Build option MULDIV_FAST_MUL_EN: multiplies use one registered 33x33
// signed product and skip the iterative MUL state.
module muldiv_unit
  import muldiv_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_start,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_in1,
  input  logic [XLEN-1:0] i_in2,
  input  logic            i_kill,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_result
);

  state_e                r_state;
  logic [ITER_BITS-1:0]  r_cnt;
  logic [2*XLEN-1:0]     r_acc;
  logic [XLEN-1:0]       r_op;
  logic [2:0]            r_funct3;
  logic                  r_s1;
  logic                  r_s2;
  logic                  r_busy;
  logic                  r_done;
  logic [XLEN-1:0]       r_result;

  logic                  w_is_div;
  logic                  w_s1;
  logic                  w_s2;
  logic [XLEN-1:0]       w_mag1;
  logic [XLEN-1:0]       w_mag2;
  logic                  w_div_zero;
  logic                  w_div_ovf;
  logic [XLEN-1:0]       w_special;
  logic [2*XLEN-1:0]     w_div_next;
  logic [2*XLEN-1:0]     w_prod;
  logic [XLEN-1:0]       w_fix_result;
`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0]     w_fast_prod;
`else
  logic [XLEN:0]         w_mul_sum;
  logic [2*XLEN-1:0]     w_mul_next;
`endif

  assign o_busy   = r_busy;
  assign o_done   = r_done;
  assign o_result = r_result;

  // Decode the incoming op: signedness, magnitudes and divide special cases.
  always_comb begin
    w_is_div   = i_funct3[2];
    w_s1       = i_in1[XLEN-1] & ((i_funct3 == F3_MULH) | (i_funct3 == F3_MULHSU) |
                                  (i_funct3 == F3_DIV)  | (i_funct3 == F3_REM));
    w_s2       = i_in2[XLEN-1] & ((i_funct3 == F3_MULH) | (i_funct3 == F3_DIV) |
                                  (i_funct3 == F3_REM));
    w_mag1     = cond_neg(i_in1, w_s1);
    w_mag2     = cond_neg(i_in2, w_s2);
    w_div_zero = (i_in2 == {XLEN{1'b0}});
    w_div_ovf  = ((i_funct3 == F3_DIV) | (i_funct3 == F3_REM)) &
                 (i_in1 == {1'b1, {(XLEN-1){1'b0}}}) & (i_in2 == {XLEN{1'b1}});
    if (w_div_zero) begin
      w_special = i_funct3[1] ? i_in1 : {XLEN{1'b1}};
    end else begin
      w_special = i_funct3[1] ? {XLEN{1'b0}} : {1'b1, {(XLEN-1){1'b0}}};
    end
  end

`ifdef MULDIV_FAST_MUL_EN
  // Full product of sign- or zero-extended operands; low 2*XLEN bits are exact.
  always_comb begin
    w_fast_prod = {{XLEN{w_s1}}, i_in1} * {{XLEN{w_s2}}, i_in2};
  end
`else
  // One shift-add step: add multiplicand on a set multiplier bit, shift right.
  always_comb begin
    if (r_acc[0]) begin
      w_mul_sum = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, r_op};
    end else begin
      w_mul_sum = {1'b0, r_acc[2*XLEN-1:XLEN]};
    end
    w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};
  end
`endif

  muldiv_divstep u_divstep (
    .i_acc     (r_acc),
    .i_divisor (r_op),
    .o_acc     (w_div_next)
  );

  // Sign fix-up and selection of product word, quotient or remainder.
  always_comb begin
`ifdef MULDIV_FAST_MUL_EN
    w_prod = r_acc;
`else
    w_prod = cond_neg2(r_acc, r_s1 ^ r_s2);
`endif
    case (r_funct3)
      F3_MUL:                        w_fix_result = w_prod[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU:  w_fix_result = w_prod[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:               w_fix_result = cond_neg(r_acc[XLEN-1:0], r_s1 ^ r_s2);
      F3_REM, F3_REMU:               w_fix_result = cond_neg(r_acc[2*XLEN-1:XLEN], r_s1);
      default:                       w_fix_result = {XLEN{1'b0}};
    endcase
  end

  // Control FSM with iteration counter, datapath registers and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= {ITER_BITS{1'b0}};
      r_acc    <= {(2*XLEN){1'b0}};
      r_op     <= {XLEN{1'b0}};
      r_funct3 <= 3'b000;
      r_s1     <= 1'b0;
      r_s2     <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= {XLEN{1'b0}};
    end else if (i_kill) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (i_start) begin
            r_busy   <= 1'b1;
            r_funct3 <= i_funct3;
            r_s1     <= w_s1;
            r_s2     <= w_s2;
            r_cnt    <= ITER_BITS'(XLEN - 1);
            if (w_is_div && (w_div_zero || w_div_ovf)) begin
              r_result <= w_special;
              r_done   <= 1'b1;
              r_state  <= ST_DONE;
            end else if (w_is_div) begin
              r_acc   <= {{XLEN{1'b0}}, w_mag1};
              r_op    <= w_mag2;
              r_state <= ST_DIV;
            end else begin
`ifdef MULDIV_FAST_MUL_EN
              r_acc   <= w_fast_prod;
              r_state <= ST_FIX;
`else
              r_acc   <= {{XLEN{1'b0}}, w_mag2};
              r_op    <= w_mag1;
              r_state <= ST_MUL;
`endif
            end
          end
        end
`ifndef MULDIV_FAST_MUL_EN
        ST_MUL: begin
          r_acc <= w_mul_next;
          if (r_cnt == {ITER_BITS{1'b0}}) begin
            r_state <= ST_FIX;
          end else begin
            r_cnt <= r_cnt - ITER_BITS'(1);
          end
        end
`endif
        ST_DIV: begin
          r_acc <= w_div_next;
          if (r_cnt == {ITER_BITS{1'b0}}) begin
            r_state <= ST_FIX;
          end else begin
            r_cnt <= r_cnt - ITER_BITS'(1);
          end
        end
        ST_FIX: begin
          r_result <= w_fix_result;
          r_done   <= 1'b1;
          r_state  <= ST_DONE;
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
